// File: rtl/vend_credit_ctrl.sv
// vend_credit_ctrl: credit and change controller for the vending machine.
// Keeps a running credit in 5-cent units, checks selections against a price
// table, sequences the dispense handshake and pays change back coin-by-coin
// through a level/ack handshake to the change hopper. All outputs registered.
module vend_credit_ctrl #(
    parameter int CREDIT_W   = 8,
    parameter int NUM_ITEMS  = 4,
    parameter int ITEM_W     = 2,
    parameter int MAX_CREDIT = 200
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            coin_valid,
    input  logic [1:0]                      coin_val,
    input  logic                            cancel,
    input  logic                            sel_valid,
    input  logic [ITEM_W-1:0]               sel_item,
    input  logic [NUM_ITEMS*CREDIT_W-1:0]   price_tbl,
    output logic                            vend_req,
    output logic [ITEM_W-1:0]               vend_item,
    input  logic                            vend_ack,
    output logic                            change_req,
    output logic [1:0]                      change_coin,
    input  logic                            change_ack,
    output logic                            coin_reject,
    output logic                            insufficient,
    output logic [CREDIT_W-1:0]             credit,
    output logic                            busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    state_t state;

    // Value in units of an inserted coin (0=5c, 1=10c, 2=25c, 3=$1).
    function automatic logic [CREDIT_W-1:0] coin_units(input logic [1:0] kind);
        logic [CREDIT_W-1:0] units;
        case (kind)
            2'd0:    units = CREDIT_W'(1);
            2'd1:    units = CREDIT_W'(2);
            2'd2:    units = CREDIT_W'(5);
            default: units = CREDIT_W'(20);
        endcase
        return units;
    endfunction

    // Largest change coin not exceeding the remaining credit (greedy payout).
    function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] amount);
        logic [1:0] kind;
        if (amount >= CREDIT_W'(5))
            kind = 2'd2;
        else if (amount >= CREDIT_W'(2))
            kind = 2'd1;
        else
            kind = 2'd0;
        return kind;
    endfunction

    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;
    logic                sel_hit;
    logic [CREDIT_W-1:0] sel_price;
    logic                sel_afford;
    logic [CREDIT_W-1:0] change_units;

    // Coin sum is formed one bit wider so the ceiling compare cannot wrap.
    always_comb begin
        coin_sum  = {1'b0, credit} + {1'b0, coin_units(coin_val)};
        coin_fits = (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    end

    // Price lookup; an index outside the table never matches and reads as unaffordable.
    always_comb begin
        sel_hit   = 1'b0;
        sel_price = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel_item == ITEM_W'(i)) begin
                sel_hit   = 1'b1;
                sel_price = price_tbl[i*CREDIT_W +: CREDIT_W];
            end
        end
        sel_afford = sel_hit && (credit >= sel_price);
    end

    // Units paid out by the change coin currently being requested.
    always_comb begin
        change_units = coin_units(change_coin);
    end

    // Main controller: state, credit and every registered output.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            credit       <= '0;
            vend_req     <= 1'b0;
            vend_item    <= '0;
            change_req   <= 1'b0;
            change_coin  <= 2'd0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            busy         <= 1'b0;
        end else begin
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            case (state)
                IDLE: begin
                    // A selection arriving with no credit is simply ignored.
                    if (coin_valid) begin
                        if (coin_fits) begin
                            credit <= coin_sum[CREDIT_W-1:0];
                            state  <= CREDIT;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end

                CREDIT: begin
                    if (cancel) begin
                        state       <= CHANGE;
                        busy        <= 1'b1;
                        change_req  <= 1'b1;
                        change_coin <= greedy_coin(credit);
                        coin_reject <= coin_valid;
                    end else if (sel_valid && sel_afford) begin
                        credit      <= credit - sel_price;
                        vend_item   <= sel_item;
                        vend_req    <= 1'b1;
                        state       <= VEND;
                        busy        <= 1'b1;
                        coin_reject <= coin_valid;
                    end else begin
                        // Refused selection leaves the coin path free to act.
                        insufficient <= sel_valid;
                        if (coin_valid) begin
                            if (coin_fits)
                                credit <= coin_sum[CREDIT_W-1:0];
                            else
                                coin_reject <= 1'b1;
                        end
                    end
                end

                VEND: begin
                    coin_reject <= coin_valid;
                    if (vend_ack) begin
                        vend_req <= 1'b0;
                        if (credit != '0) begin
                            state       <= CHANGE;
                            change_req  <= 1'b1;
                            change_coin <= greedy_coin(credit);
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                CHANGE: begin
                    coin_reject <= coin_valid;
                    if (change_req) begin
                        if (change_ack) begin
                            change_req <= 1'b0;
                            credit     <= credit - change_units;
                            if (credit == change_units) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end else begin
                        // One idle cycle after each ack, then request the next coin.
                        change_req  <= 1'b1;
                        change_coin <= greedy_coin(credit);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Testbench for vend_credit_ctrl: directed scenarios with literal expectations
// followed by randomized traffic, all compared every cycle against a
// behavioural model of the credit/vend/change rules.
module tb_vend_credit_ctrl;

    localparam int CREDIT_W   = 8;
    localparam int NUM_ITEMS  = 4;
    localparam int ITEM_W     = 2;
    localparam int MAX_CREDIT = 200;

    logic                          clk = 1'b0;
    logic                          resetn = 1'b0;
    logic                          coin_valid = 1'b0;
    logic [1:0]                    coin_val = 2'd0;
    logic                          cancel = 1'b0;
    logic                          sel_valid = 1'b0;
    logic [ITEM_W-1:0]             sel_item = '0;
    logic [NUM_ITEMS*CREDIT_W-1:0] price_tbl = '0;
    logic                          vend_req;
    logic [ITEM_W-1:0]             vend_item;
    logic                          vend_ack = 1'b0;
    logic                          change_req;
    logic [1:0]                    change_coin;
    logic                          change_ack = 1'b0;
    logic                          coin_reject;
    logic                          insufficient;
    logic [CREDIT_W-1:0]           credit;
    logic                          busy;

    vend_credit_ctrl #(
        .CREDIT_W(CREDIT_W), .NUM_ITEMS(NUM_ITEMS), .ITEM_W(ITEM_W), .MAX_CREDIT(MAX_CREDIT)
    ) dut (
        .clk(clk), .resetn(resetn), .coin_valid(coin_valid), .coin_val(coin_val),
        .cancel(cancel), .sel_valid(sel_valid), .sel_item(sel_item), .price_tbl(price_tbl),
        .vend_req(vend_req), .vend_item(vend_item), .vend_ack(vend_ack),
        .change_req(change_req), .change_coin(change_coin), .change_ack(change_ack),
        .coin_reject(coin_reject), .insufficient(insufficient), .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: money held, whether a dispense or a refund is under way.
    int m_credit;
    bit m_vending, m_refunding;
    bit m_vreq, m_creq, m_rej, m_ins;
    int m_vitem, m_ccoin;
    int prices[NUM_ITEMS];

    function automatic int coin_worth(input int kind);
        case (kind)
            0: return 1;
            1: return 2;
            2: return 5;
            default: return 20;
        endcase
    endfunction

    function automatic int best_coin(input int amount);
        if (amount >= 5) return 2;
        if (amount >= 2) return 1;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_credit = 0; m_vending = 0; m_refunding = 0;
        m_vreq = 0; m_creq = 0; m_rej = 0; m_ins = 0;
        m_vitem = 0; m_ccoin = 0;
    endtask

    task automatic start_refund();
        m_refunding = 1;
        m_creq = 1;
        m_ccoin = best_coin(m_credit);
    endtask

    task automatic take_coin(input bit cv, input int ct);
        if (cv) begin
            if (m_credit + coin_worth(ct) <= MAX_CREDIT) m_credit += coin_worth(ct);
            else m_rej = 1;
        end
    endtask

    // One clock of the rules, applied to the inputs presented in that cycle.
    task automatic model_step(input bit cv, input int ct, input bit can, input bit sv,
                              input int it, input bit va, input bit ca);
        m_rej = 0;
        m_ins = 0;
        if (m_vending) begin
            m_rej = cv;
            if (va) begin
                m_vending = 0;
                m_vreq = 0;
                if (m_credit > 0) start_refund();
            end
        end else if (m_refunding) begin
            m_rej = cv;
            if (!m_creq) begin
                m_creq = 1;
                m_ccoin = best_coin(m_credit);
            end else if (ca) begin
                m_credit -= coin_worth(m_ccoin);
                m_creq = 0;
                if (m_credit == 0) m_refunding = 0;
            end
        end else if (m_credit == 0) begin
            take_coin(cv, ct);
        end else if (can) begin
            m_rej = cv;
            start_refund();
        end else if (sv && it < NUM_ITEMS && m_credit >= prices[it]) begin
            m_rej = cv;
            m_credit -= prices[it];
            m_vending = 1;
            m_vreq = 1;
            m_vitem = it;
        end else begin
            m_ins = sv;
            take_coin(cv, ct);
        end
    endtask

    task automatic compare_all();
        chk("credit", 32'(credit), m_credit);
        chk("busy", 32'(busy), int'(m_vending || m_refunding));
        chk("vend_req", 32'(vend_req), int'(m_vreq));
        if (m_vreq) chk("vend_item", 32'(vend_item), m_vitem);
        chk("change_req", 32'(change_req), int'(m_creq));
        if (m_creq) chk("change_coin", 32'(change_coin), m_ccoin);
        chk("coin_reject", 32'(coin_reject), int'(m_rej));
        chk("insufficient", 32'(insufficient), int'(m_ins));
    endtask

    // Present one cycle of inputs, step the model at the edge, compare just after.
    task automatic cycle(input bit cv, input int ct, input bit can, input bit sv,
                         input int it, input bit va, input bit ca);
        @(negedge clk);
        coin_valid = cv; coin_val = 2'(ct); cancel = can;
        sel_valid = sv; sel_item = ITEM_W'(it); vend_ack = va; change_ack = ca;
        @(posedge clk);
        model_step(cv, ct, can, sv, it, va, ca);
        #1;
        compare_all();
    endtask

    task automatic idle_cycle();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic coin(input int ct);
        cycle(1, ct, 0, 0, 0, 0, 0);
    endtask

    task automatic set_prices(input int p0, input int p1, input int p2, input int p3);
        prices[0] = p0; prices[1] = p1; prices[2] = p2; prices[3] = p3;
        for (int i = 0; i < NUM_ITEMS; i++)
            price_tbl[i*CREDIT_W +: CREDIT_W] = CREDIT_W'(prices[i]);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_credit"}, 32'(credit), 0);
        chk({tag, "_vend_req"}, 32'(vend_req), 0);
        chk({tag, "_change_req"}, 32'(change_req), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_reject"}, 32'(coin_reject), 0);
        chk({tag, "_insuff"}, 32'(insufficient), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        set_prices(3, 6, 0, 50);
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        resetn = 1'b1;

        // Coins 25c then 10c.
        coin(2);
        chk("t1_credit5", 32'(credit), 5);
        coin(1);
        chk("t1_credit7", 32'(credit), 7);
        chk("t1_busy", 32'(busy), 0);

        // Vend item 1 at price 6, then one 5c change coin.
        cycle(0, 0, 0, 1, 1, 0, 0);
        chk("t2_vend_req", 32'(vend_req), 1);
        chk("t2_vend_item", 32'(vend_item), 1);
        chk("t2_credit", 32'(credit), 1);
        idle_cycle();
        idle_cycle();
        chk("t2_vend_held", 32'(vend_req), 1);
        cycle(0, 0, 0, 0, 0, 1, 0);
        chk("t2_vend_drop", 32'(vend_req), 0);
        chk("t2_chg_req", 32'(change_req), 1);
        chk("t2_chg_coin", 32'(change_coin), 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("t2_final_credit", 32'(credit), 0);
        chk("t2_final_busy", 32'(busy), 0);

        // Insufficient credit.
        coin(1);
        coin(1);
        cycle(0, 0, 0, 1, 1, 0, 0);
        chk("t3_insufficient", 32'(insufficient), 1);
        chk("t3_credit", 32'(credit), 4);
        chk("t3_no_vend", 32'(vend_req), 0);
        idle_cycle();
        chk("t3_pulse_once", 32'(insufficient), 0);

        // Credit 12, cancel, change 25c/25c/10c with delayed acks.
        coin(2);
        coin(1);
        coin(0);
        chk("t4_credit12", 32'(credit), 12);
        cycle(0, 0, 1, 0, 0, 0, 0);
        chk("t4_req1", 32'(change_req), 1);
        chk("t4_coin1", 32'(change_coin), 2);
        repeat (3) begin
            idle_cycle();
            chk("t4_coin1_stable", 32'(change_coin), 2);
        end
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("t4_credit7", 32'(credit), 7);
        chk("t4_gap", 32'(change_req), 0);
        idle_cycle();
        chk("t4_coin2", 32'(change_coin), 2);
        repeat (3) idle_cycle();
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("t4_credit2", 32'(credit), 2);
        idle_cycle();
        chk("t4_coin3", 32'(change_coin), 1);
        repeat (3) begin
            idle_cycle();
            chk("t4_coin3_stable", 32'(change_coin), 1);
        end
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("t4_credit0", 32'(credit), 0);
        chk("t4_idle", 32'(busy), 0);

        // Ceiling: 195 then a $1 coin.
        repeat (9) coin(3);
        repeat (3) coin(2);
        chk("t5_credit195", 32'(credit), 195);
        coin(3);
        chk("t5_reject", 32'(coin_reject), 1);
        chk("t5_credit_kept", 32'(credit), 195);

        // Cancel + selection + coin together: cancel wins.
        cycle(1, 0, 1, 1, 0, 0, 0);
        chk("t6_reject", 32'(coin_reject), 1);
        chk("t6_no_vend", 32'(vend_req), 0);
        chk("t6_chg_req", 32'(change_req), 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("t6_credit190", 32'(credit), 190);
        idle_cycle();

        // Asynchronous reset in the middle of a change request.
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("t6_async");
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Coin during VEND is returned.
        coin(2);
        coin(1);
        cycle(0, 0, 0, 1, 1, 0, 0);
        coin(0);
        chk("t7_vend_reject", 32'(coin_reject), 1);
        chk("t7_credit", 32'(credit), 1);
        cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("t7_idle", 32'(busy), 0);

        // Randomized traffic in blocks with fresh price tables.
        for (int blk = 0; blk < 8; blk++) begin
            set_prices($urandom_range(0, 40), $urandom_range(0, 20),
                       $urandom_range(0, 60), $urandom_range(0, 10));
            for (int n = 0; n < 500; n++) begin
                bit cv, can, sv, va, ca;
                cv  = ($urandom_range(0, 2) == 0);
                can = ($urandom_range(0, 24) == 0);
                sv  = ($urandom_range(0, 5) == 0);
                va  = m_vreq ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
                ca  = m_creq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
                cycle(cv, $urandom_range(0, 3), can, sv, $urandom_range(0, NUM_ITEMS-1), va, ca);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_credit_ctrl.md
Name: vend_credit_ctrl

Overview:
Credit and change controller for the vending machine.
- Accepts coins and keeps a running credit in 5-cent units.
- Checks item selections against a price table and sequences the dispense handshake.
- Pays change back coin-by-coin through a handshake to the change hopper.
- Sits between the coin acceptor/keypad front end and the dispense and change mechanisms.

Parameters:
CREDIT_W, 8, width of the credit register and price entries, in 5-cent units
NUM_ITEMS, 4, number of selectable items
ITEM_W, 2, width of the item index; must equal clog2(NUM_ITEMS)
MAX_CREDIT, 200, credit ceiling in units; coins that would exceed it are rejected

Ports:
clk  in  1  clock, rising edge
resetn  in  1  reset; asynchronous, active-low
coin_valid  in  1  one-cycle pulse: coin inserted
coin_val  in  2  coin type: 0=1 unit (5c), 1=2 (10c), 2=5 (25c), 3=20 ($1)
cancel  in  1  one-cycle pulse: return all credit
sel_valid  in  1  one-cycle pulse: selection made
sel_item  in  ITEM_W  selected item index
price_tbl  in  NUM_ITEMS*CREDIT_W  packed prices; item i at bits [i*CREDIT_W +: CREDIT_W]
vend_req  out  1  level: dispense sel_item, held until vend_ack
vend_item  out  ITEM_W  item being dispensed; stable while vend_req=1
vend_ack  in  1  dispenser done
change_req  out  1  level: eject one change coin, held until change_ack
change_coin  out  2  change coin type; stable while change_req=1: 0=1 unit, 1=2, 2=5
change_ack  in  1  hopper ejected the coin
coin_reject  out  1  one-cycle pulse: coin not accepted; the acceptor returns it
insufficient  out  1  one-cycle pulse: selection refused for low credit
credit  out  CREDIT_W  current credit, registered
busy  out  1  state is VEND or CHANGE

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE, credit=0, all outputs 0.
- All outputs are registered. credit and state update one cycle after the accepting input.
- States:
  - IDLE: credit==0.
  - CREDIT: credit>0, accepting coins and selections.
  - VEND: waiting for vend_ack.
  - CHANGE: returning credit.
- Coin acceptance:
  - Accepted only in IDLE or CREDIT.
  - If credit + value(coin_val) <= MAX_CREDIT: credit += value, IDLE->CREDIT.
  - Otherwise: coin_reject pulses next cycle and credit is unchanged.
  - A coin_valid in VEND or CHANGE is rejected (coin_reject pulses).
- Priority in CREDIT, same cycle: cancel > sel_valid > coin_valid.
  - A coin arriving alongside an accepted cancel or selection is rejected.
  - In IDLE, a coin arriving with sel_valid is accepted; the selection is ignored.
- cancel:
  - In CREDIT: go to CHANGE.
  - In IDLE, VEND or CHANGE: ignored.
- Selection in CREDIT, with p = price_tbl[sel_item]:
  - If credit >= p: credit -= p, vend_item=sel_item, vend_req=1, go to VEND.
  - Else: insufficient pulses one cycle, state and credit unchanged.
  - sel_item >= NUM_ITEMS is treated as insufficient.
  - Price 0 is legal and vends for free.
- sel_valid in IDLE or VEND or CHANGE: ignored (no insufficient pulse).
- VEND: hold vend_req and vend_item until vend_ack is sampled high. Then vend_req=0 next cycle, and go to CHANGE if credit>0, else IDLE.
- CHANGE, greedy coin selection:
  - change_coin = 2 if credit>=5, else 1 if credit>=2, else 0.
  - Assert change_req with change_coin stable.
  - On change_ack: credit -= value(change_coin) and change_req drops for one cycle.
  - If credit is then 0, go to IDLE; otherwise re-evaluate and request again.
  - Minimum spacing between requests is 2 cycles.
- vend_ack / change_ack outside their handshake: ignored.
- Reset mid-handshake: requests drop immediately and credit is lost (0). This is acceptable by design.
- Arithmetic: credit is never negative and never exceeds MAX_CREDIT. Sums are computed CREDIT_W+1 wide before the compare.

Test Plan:
- Reset, insert 25c (val 2) then 10c (val 1) -> credit 5 then 7, state CREDIT, busy=0.
- credit=7, price_tbl[1]=6, select item 1 -> vend_req=1 with vend_item=1 until vend_ack; then credit=1, one change_req with coin 0, ack -> credit=0, IDLE.
- credit=4, select item with price 6 -> insufficient pulses once, credit stays 4, no vend_req.
- credit=12, cancel -> change sequence coin 2, coin 2, coin 1, with acks each delayed 3 cycles -> credit 7, 2, 0, then IDLE; change_coin stable while each request is pending.
- credit=195 (MAX_CREDIT=200), insert $1 (val 3) -> coin_reject pulses, credit stays 195; coin during VEND -> coin_reject pulses.
- Same cycle cancel + sel_valid + coin_valid in CREDIT -> cancel wins, coin_reject pulses, no vend; assert resetn low during CHANGE -> all outputs 0 immediately, credit 0.
